// File: rtl/leaf_user_in_fifo.sv
// Per-port input buffer between the leaf interface and an HLS ap_fifo input stream, with a registered FWFT read port.
// Optional statistics ports (word_count, max_occupancy, ovf_err) are enabled by defining LEAF_USER_IN_FIFO_STATS_EN.
module leaf_user_in_fifo #(
   parameter int PAYLOAD_BITS = 32,
   parameter int DEPTH_BITS   = 4,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                    clk_user,
   input  logic                    reset,
   input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
   input  logic                    vld_interface2user,
   output logic                    ack_user2interface,
   output logic [PAYLOAD_BITS-1:0] user_dout,
   output logic                    user_empty_n,
   input  logic                    user_read,
   output logic [DEPTH_BITS:0]     occupancy
`ifdef LEAF_USER_IN_FIFO_STATS_EN
   ,
   output logic [31:0]             word_count,
   output logic [DEPTH_BITS:0]     max_occupancy,
   output logic [0:0]              ovf_err
`endif
);

   localparam int                  DEPTH    = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] DEPTH_W  = (DEPTH_BITS+1)'(DEPTH);
   localparam logic [DEPTH_BITS:0] MARGIN_W = (DEPTH_BITS+1)'(AFULL_MARGIN);

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];
   logic [DEPTH_BITS-1:0]   wptr;
   logic [DEPTH_BITS-1:0]   rptr;
   logic [DEPTH_BITS:0]     mem_count;
   logic [DEPTH_BITS:0]     mem_count_next;
   logic [DEPTH_BITS:0]     occ_next;
   logic                    wr_attempt;
   logic                    full;
   logic                    wr_en;
   logic                    pop;
   logic                    load;

`ifndef LEAF_USER_IN_FIFO_STATS_EN
   logic [0:0] ovf_err;
   logic       unused_ovf_err;
   assign unused_ovf_err = ovf_err[0];
`endif

   assign wr_attempt = vld_interface2user && ack_user2interface;
   assign full       = (occupancy == DEPTH_W);
   assign wr_en      = wr_attempt && !full;
   assign pop        = user_read && user_empty_n;
   // Refill the output stage only from words already in memory; no write-to-output bypass.
   assign load       = (mem_count != '0) && (!user_empty_n || pop);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      occ_next       = occupancy;
      mem_count_next = mem_count;
      case ({wr_en, pop})
         2'b10:   occ_next = occupancy + 1'b1;
         2'b01:   occ_next = occupancy - 1'b1;
         default: occ_next = occupancy;
      endcase
      case ({wr_en, load})
         2'b10:   mem_count_next = mem_count + 1'b1;
         2'b01:   mem_count_next = mem_count - 1'b1;
         default: mem_count_next = mem_count;
      endcase
   end

   // NOTE: the storage array has no reset so it maps onto distributed RAM; stale contents are never read.
   always_ff @(posedge clk_user) begin
      if (wr_en) mem[wptr] <= dout_leaf_interface2user;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_user) begin
      if (reset) begin
         wptr               <= '0;
         rptr               <= '0;
         mem_count          <= '0;
         occupancy          <= '0;
         ack_user2interface <= 1'b0;
         user_empty_n       <= 1'b0;
         user_dout          <= '0;
         ovf_err            <= 1'b0;
      end else begin
         if (wr_en) wptr <= wptr + DEPTH_BITS'(1);
         if (load)  rptr <= rptr + DEPTH_BITS'(1);
         mem_count <= mem_count_next;
         occupancy <= occ_next;
         // Ack is computed from the post-edge count, so it is withdrawn before the buffer can overflow.
         ack_user2interface <= (DEPTH_W - occ_next) > MARGIN_W;
         if (load) user_dout <= mem[rptr];
         user_empty_n <= load || (user_empty_n && !pop);
         if (wr_attempt && full) ovf_err <= 1'b1;
      end
   end

`ifdef LEAF_USER_IN_FIFO_STATS_EN
   always_ff @(posedge clk_user) begin
      if (reset) begin
         word_count    <= '0;
         max_occupancy <= '0;
      end else begin
         if (wr_en) word_count <= word_count + 32'd1;
         if (occ_next > max_occupancy) max_occupancy <= occ_next;
      end
   end
`endif

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Self-checking bench for leaf_user_in_fifo: directed vector table, hand-written corner sequences and a queue-based random model.
// Stats ports are checked when LEAF_USER_IN_FIFO_STATS_EN is defined.
module tb_leaf_user_in_fifo;

   logic        clk_user = 1'b0;
   logic        reset;
   logic [31:0] din;
   logic        vld;
   logic        ack;
   logic [31:0] user_dout;
   logic        user_empty_n;
   logic        user_read;
   logic [4:0]  occupancy;
`ifdef LEAF_USER_IN_FIFO_STATS_EN
   logic [31:0] word_count;
   logic [4:0]  max_occupancy;
   logic [0:0]  ovf_err;
`endif

   leaf_user_in_fifo dut (
      .clk_user                 (clk_user),
      .reset                    (reset),
      .dout_leaf_interface2user (din),
      .vld_interface2user       (vld),
      .ack_user2interface       (ack),
      .user_dout                (user_dout),
      .user_empty_n             (user_empty_n),
      .user_read                (user_read),
      .occupancy                (occupancy)
`ifdef LEAF_USER_IN_FIFO_STATS_EN
      ,
      .word_count               (word_count),
      .max_occupancy            (max_occupancy),
      .ovf_err                  (ovf_err)
`endif
   );

   always #5 clk_user = ~clk_user;

   int checks = 0;
   int errors = 0;

   // Reference model: the buffer is a plain queue; the head is visible once some word
   // other than the one being popped was already stored before the edge.
   logic [31:0] q[$];
   logic        m_vis;
   logic        m_ack;
   int          m_wc;
   int          m_max;
   int          popped;
   int          exp_next;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("empty_n", 32'(user_empty_n), 32'(m_vis));
      check("occupancy", 32'(occupancy), 32'(q.size()));
      check("ack", 32'(ack), 32'(m_ack));
      if (m_vis) check("dout", user_dout, q[0]);
`ifdef LEAF_USER_IN_FIFO_STATS_EN
      check("word_count", word_count, 32'(m_wc));
      check("max_occupancy", 32'(max_occupancy), 32'(m_max));
      check("ovf_err", 32'(ovf_err), 32'd0);
`endif
   endtask

   // Drive one cycle's inputs (called right after a negedge sample) and advance the model.
   task automatic apply(input logic r, input logic v, input logic [31:0] d, input logic rd);
      int pre;
      logic wr, pp;
      reset = r; vld = v; din = d; user_read = rd;
      if (r) begin
         q.delete(); m_vis = 1'b0; m_ack = 1'b0; m_wc = 0; m_max = 0;
      end else begin
         wr  = v && m_ack;
         pp  = rd && m_vis;
         pre = q.size();
         if (pp) begin
            if (q[0] == 32'(exp_next)) exp_next++;
            popped++;
            void'(q.pop_front());
         end
         if (wr) begin q.push_back(d); m_wc++; end
         m_vis = (pre - int'(pp)) > 0;
         m_ack = (16 - q.size()) > 2;
         if (q.size() > m_max) m_max = q.size();
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [31:0] d, input logic rd);
      @(negedge clk_user);
      check_model();
      apply(r, v, d, rd);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   typedef struct {
      logic        vld;
      logic [31:0] data;
      logic        rd;
      logic        exp_empty_n;
      logic [4:0]  exp_occ;
      logic        exp_ack;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [31:0] nxt;
      vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0};
      vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd1, 1'b1, 32'h0};
      vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 5'd1, 1'b1, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 32'h1,        1'b0, 1'b0, 5'd0, 1'b1, 32'h0};
      vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd1, 1'b1, 32'h0};
      vecs[5] = '{1'b1, 32'h2,        1'b1, 1'b1, 5'd1, 1'b1, 32'h1};
      vecs[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd1, 1'b1, 32'h0};
      vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 5'd1, 1'b1, 32'h2};
      vecs[8] = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd0, 1'b1, 32'h0};

      reset = 1'b1; vld = 1'b0; din = '0; user_read = 1'b0;
      q.delete(); m_vis = 0; m_ack = 0; m_wc = 0; m_max = 0; popped = 0; exp_next = 0;
      for (int i = 0; i < 3; i++) @(negedge clk_user);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_empty_n", 32'(user_empty_n), 32'd0);
      check("reset_dout", user_dout, 32'd0);
      check("reset_occ", 32'(occupancy), 32'd0);
      apply(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);

      // Directed table: single write latency, pop, ignored empty read, pop with same-cycle write.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_user);
         check($sformatf("vec%0d_empty_n", i), 32'(user_empty_n), 32'(vecs[i].exp_empty_n));
         check($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].exp_occ));
         check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
         if (vecs[i].exp_empty_n) check($sformatf("vec%0d_dout", i), user_dout, vecs[i].exp_dout);
         check_model();
         apply(1'b0, vecs[i].vld, vecs[i].data, vecs[i].rd);
      end

      // vld held high with no reads: ack withdraws at 14 words and nothing overflows.
      do_reset();
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 32'(100 + i), 1'b0);
      @(negedge clk_user);
      check("afull_occ", 32'(occupancy), 32'd14);
      check("afull_ack", 32'(ack), 32'd0);
      check_model();
      apply(1'b0, 1'b0, 32'd0, 1'b0);

      // Fill with ascending words, then stream reads while writing up to 40: order preserved across wraps.
      do_reset();
      popped = 0; exp_next = 0; nxt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_user);
         check_model();
         if (ack && nxt <= 32'd15) begin apply(1'b0, 1'b1, nxt, 1'b0); nxt++; end
         else apply(1'b0, 1'b0, 32'd0, 1'b0);
      end
      for (int i = 0; i < 200 && popped < 41; i++) begin
         @(negedge clk_user);
         check_model();
         if (ack && nxt <= 32'd40) begin apply(1'b0, 1'b1, nxt, 1'b1); nxt++; end
         else apply(1'b0, 1'b0, 32'd0, 1'b1);
      end
      check("stream_pop_count", 32'(popped), 32'd41);
      check("stream_in_order", 32'(exp_next), 32'd41);

      // Steady state at 8 words with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'(500 + i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'(600 + i), 1'b1);
      @(negedge clk_user);
      check("steady_occ", 32'(occupancy), 32'd8);
      check_model();
      apply(1'b0, 1'b0, 32'd0, 1'b0);

      // Reads while empty are ignored; a later write still reads back.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 32'h0BADF00D, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      @(negedge clk_user);
      check("after_empty_reads_dout", user_dout, 32'h0BADF00D);
      check("after_empty_reads_occ", 32'(occupancy), 32'd1);
      check_model();
      apply(1'b0, 1'b0, 32'd0, 1'b0);

      // Reset mid-operation at occupancy 10.
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'(700 + i), 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0);
      @(negedge clk_user);
      check("midreset_occ", 32'(occupancy), 32'd0);
      check("midreset_empty_n", 32'(user_empty_n), 32'd0);
      check("midreset_ack", 32'(ack), 32'd0);
`ifdef LEAF_USER_IN_FIFO_STATS_EN
      check("midreset_word_count", word_count, 32'd0);
      check("midreset_max_occ", 32'(max_occupancy), 32'd0);
`endif
      apply(1'b0, 1'b0, 32'd0, 1'b0);
      @(negedge clk_user);
      check("release_ack", 32'(ack), 32'd1);
      check_model();
      apply(1'b0, 1'b0, 32'd0, 1'b0);

      // Randomised traffic with varying read/write pressure and rare resets.
      for (int i = 0; i < 3000; i++) begin
         int wp, rp;
         wp = (i / 500) % 2 == 0 ? 70 : 40;
         rp = (i / 500) % 2 == 0 ? 40 : 75;
         step($urandom_range(0, 399) == 0, $urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp);
      end
      @(negedge clk_user);
      check_model();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
